digi_source_seq: RTL

Clocked digital stimulus source feeding the logic-gate stage (AND/NAND/OR/XOR/Inv inputs) in gate-level testbenches. Stores a short list of {output word, hold time} entries written over a valid/ready port, then plays them back on `dout`, holding each word for its programmed number of cycles. It is the synthesizable counterpart of the Qucs digital source: an initial level, then timed transitions.

---
 rtl/digi_source_pkg.sv | 14 +
 rtl/digi_source_seq_if.sv | 13 +
 rtl/digi_source_buf.sv | 70 +++++++
 rtl/digi_source_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/digi_source_pkg.sv
// Shared types and helpers for the digital stimulus source.
package digi_source_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Width needed to count 0..depth stored entries.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/digi_source_seq_if.sv
// Entry write port of digi_source_seq: one {word, hold} entry per valid&&ready.
interface digi_source_seq_if #(
  parameter int W     = 2,
  parameter int CNT_W = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [W-1:0]     wr_word;
  logic [CNT_W-1:0] wr_hold;

  modport master (output wr_valid, wr_word, wr_hold, input wr_ready);
  modport slave  (input wr_valid, wr_word, wr_hold, output wr_ready);
endinterface

// File: rtl/digi_source_buf.sv
// Circular entry store for digi_source_seq. With DIGI_SOURCE_LOOP_EN a separate
// play pointer walks the stored entries and wraps back to the oldest one.
module digi_source_buf #(
  parameter int EW    = 18,
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [EW-1:0] push_ent,
  input  logic          pop,
  input  logic          flush,
`ifdef DIGI_SOURCE_LOOP_EN
  input  logic          lp,
  input  logic          adv,
  input  logic          rewind,
`endif
  output logic [EW-1:0] head,
  output logic [EW-1:0] nxt,
  output logic [LW-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr, rd, nx;

`ifdef DIGI_SOURCE_LOOP_EN
  logic [PW-1:0] cur, cur_nxt;

  // Writes are blocked while looping, so wptr marks the end of the stored list.
  assign cur_nxt = (cur + PW'(1) == wptr) ? rptr : cur + PW'(1);
  assign rd      = lp ? cur : rptr;
  assign nx      = lp ? cur_nxt : rptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cur <= '0;
    else if (flush)  cur <= '0;
    else if (rewind) cur <= rptr;
    else if (adv)    cur <= cur_nxt;
  end
`else
  assign rd = rptr;
  assign nx = rptr + PW'(1);
`endif

  assign head = mem[rd];
  assign nxt  = mem[nx];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/digi_source_seq.sv
// Timed digital stimulus source: plays back stored {word, hold} entries on dout.
// Optional continuous replay is enabled by defining DIGI_SOURCE_LOOP_EN.
module digi_source_seq
  import digi_source_pkg::*;
#(
  parameter int           W     = 2,
  parameter int           CNT_W = 16,
  parameter int           DEPTH = 8,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  digi_source_seq_if.slave        wr,
  input  logic                    start,
  input  logic                    stop,
`ifdef DIGI_SOURCE_LOOP_EN
  input  logic                    loop,
`endif
  output logic [W-1:0]            dout,
  output logic                    busy,
  output logic                    done,
  output logic [lvl_w(DEPTH)-1:0] level
);
  localparam int LW = lvl_w(DEPTH);

  typedef struct packed {
    logic [W-1:0]     word;
    logic [CNT_W-1:0] hold;
  } ent_t;

  state_t           state;
  logic             act;
  logic [CNT_W-1:0] cnt;
  logic             lp_q;
  ent_t             head, nxt, wr_ent;
  logic             push, pop, flush, cmp, more, go;

  function automatic logic [CNT_W-1:0] hold_ld(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - CNT_W'(1);
  endfunction

  assign wr.wr_ready = (level != LW'(DEPTH)) && !(busy && lp_q);
  assign wr_ent      = '{word: wr.wr_word, hold: wr.wr_hold};
  assign push        = wr.wr_valid && wr.wr_ready && !stop;
  assign go          = (state == IDLE) && start && (level != '0) && !stop;
  // cmp: the word on dout has just finished its last hold cycle.
  assign cmp         = (state == PLAY) && act && (cnt == '0);
  assign more        = lp_q || (level > LW'(1));
  assign pop         = cmp && !stop && !lp_q;
  assign flush       = stop && !lp_q;

`ifdef DIGI_SOURCE_LOOP_EN
  logic adv;
  assign adv = cmp && !stop && lp_q;
`else
  assign lp_q = 1'b0;
`endif

  digi_source_buf #(.EW($bits(ent_t)), .DEPTH(DEPTH), .LW(LW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_ent (wr_ent),
    .pop      (pop),
    .flush    (flush),
`ifdef DIGI_SOURCE_LOOP_EN
    .lp       (lp_q),
    .adv      (adv),
    .rewind   (go),
`endif
    .head     (head),
    .nxt      (nxt),
    .level    (level)
  );

  // act=0 marks the first PLAY cycle, which only loads the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act   <= 1'b0;
      cnt   <= '0;
      dout  <= INIT;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DIGI_SOURCE_LOOP_EN
      lp_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        act   <= 1'b0;
        cnt   <= '0;
        dout  <= INIT;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            state <= PLAY;
            busy  <= 1'b1;
            act   <= 1'b0;
`ifdef DIGI_SOURCE_LOOP_EN
            lp_q  <= loop;
`endif
          end
          PLAY: begin
            if (!act) begin
              dout <= head.word;
              cnt  <= hold_ld(head.hold);
              act  <= 1'b1;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (more) begin
              dout <= nxt.word;
              cnt  <= hold_ld(nxt.hold);
            end else begin
              state <= IDLE;
              act   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
